// File: rtl/instr_fetch.sv
// instr_fetch: fetch stage ahead of the immediate generator and decoder.
// Holds the program counter, issues one single-word read per instruction,
// captures the returned word into ir and holds it until the consumer
// acknowledges it. The PC then advances by 4 or loads a redirect target.
//
// Parameters:
//   RESET_PC   PC loaded on reset (4-byte aligned)
//   NOP_INSTR  ir value on reset
//
// Ports:
//   clk            system clock, rising edge
//   reset          synchronous, active-high reset
//   imem_addr      fetch address (= pc), meaningful while imem_rd_en = 1
//   imem_rd_en     read strobe, one cycle per fetch
//   imem_rd_data   instruction word from memory
//   imem_rd_valid  imem_rd_data valid this cycle
//   ir             registered instruction
//   pc             address of the instruction held in ir
//   pc_plus4       pc + 4, combinational, wraps mod 2^32
//   ir_valid       ir holds a freshly fetched instruction (registered)
//   ir_ack         consumer done with ir; advance (HOLD only)
//   pc_load        redirect select, sampled only with ir_ack
//   pc_load_value  redirect target
//   fetch_fault    (FETCH_MISALIGN_TRAP_EN only) sticky misaligned-redirect trap
//
// Optional feature macro: FETCH_MISALIGN_TRAP_EN
//   Defined:   misaligned redirect sets fetch_fault and parks in FAULT until reset.
//   Undefined: low two bits of the redirect target are cleared silently.

module instr_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_addr,
  output logic        imem_rd_en,
  input  logic [31:0] imem_rd_data,
  input  logic        imem_rd_valid,
  output logic [31:0] ir,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        ir_valid,
  input  logic        ir_ack,
  input  logic        pc_load,
  input  logic [31:0] pc_load_value
`ifdef FETCH_MISALIGN_TRAP_EN
  ,
  output logic        fetch_fault
`endif
);

`ifdef FETCH_MISALIGN_TRAP_EN
  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD, S_FAULT} state_t;
`else
  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD} state_t;
`endif

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_pc;
  logic [31:0] w_pc_nxt;
  logic [31:0] r_ir;
  logic [31:0] w_ir_nxt;
  logic        r_ir_valid;
  logic        w_ir_valid_nxt;
  logic        w_rd_en;
  logic [31:0] w_pc_plus4;
  logic [31:0] w_load_target;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic        r_fault;
  logic        w_fault_nxt;
  logic        w_misaligned;

  assign w_misaligned = |pc_load_value[1:0];
`endif

  assign w_pc_plus4    = r_pc + 32'd4;
  // Masking instead of slicing keeps every target bit in use.
  assign w_load_target = pc_load_value & 32'hFFFF_FFFC;

  always_comb begin
    w_state_nxt    = r_state;
    w_pc_nxt       = r_pc;
    w_ir_nxt       = r_ir;
    w_ir_valid_nxt = r_ir_valid;
    w_rd_en        = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
    w_fault_nxt    = r_fault;
`endif
    case (r_state)
      S_REQ: begin
        w_rd_en     = 1'b1;
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (imem_rd_valid) begin
          w_ir_nxt       = imem_rd_data;
          w_ir_valid_nxt = 1'b1;
          w_state_nxt    = S_HOLD;
        end
      end
      S_HOLD: begin
        if (ir_ack) begin
          w_ir_valid_nxt = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
          if (pc_load && w_misaligned) begin
            w_fault_nxt = 1'b1;
            w_state_nxt = S_FAULT;
          end else begin
            w_pc_nxt    = pc_load ? w_load_target : w_pc_plus4;
            w_state_nxt = S_REQ;
          end
`else
          w_pc_nxt    = pc_load ? w_load_target : w_pc_plus4;
          w_state_nxt = S_REQ;
`endif
        end
      end
`ifdef FETCH_MISALIGN_TRAP_EN
      S_FAULT: begin
        w_state_nxt = S_FAULT;
      end
`endif
      default: begin
        w_state_nxt = S_REQ;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_REQ;
      r_pc       <= RESET_PC;
      r_ir       <= NOP_INSTR;
      r_ir_valid <= 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
      r_fault    <= 1'b0;
`endif
    end else begin
      r_state    <= w_state_nxt;
      r_pc       <= w_pc_nxt;
      r_ir       <= w_ir_nxt;
      r_ir_valid <= w_ir_valid_nxt;
`ifdef FETCH_MISALIGN_TRAP_EN
      r_fault    <= w_fault_nxt;
`endif
    end
  end

  assign imem_addr  = r_pc;
  assign imem_rd_en = w_rd_en;
  assign ir         = r_ir;
  assign pc         = r_pc;
  assign pc_plus4   = w_pc_plus4;
  assign ir_valid   = r_ir_valid;
`ifdef FETCH_MISALIGN_TRAP_EN
  assign fetch_fault = r_fault;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;

  logic        clk;
  logic        reset;
  logic [31:0] imem_addr;
  logic        imem_rd_en;
  logic [31:0] imem_rd_data;
  logic        imem_rd_valid;
  logic [31:0] ir;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        ir_valid;
  logic        ir_ack;
  logic        pc_load;
  logic [31:0] pc_load_value;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic        fetch_fault;
`endif

  int unsigned n_cmp;
  int unsigned n_err;

  instr_fetch #(
    .RESET_PC  (32'h0000_0000),
    .NOP_INSTR (32'h0000_0013)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .imem_addr     (imem_addr),
    .imem_rd_en    (imem_rd_en),
    .imem_rd_data  (imem_rd_data),
    .imem_rd_valid (imem_rd_valid),
    .ir            (ir),
    .pc            (pc),
    .pc_plus4      (pc_plus4),
    .ir_valid      (ir_valid),
    .ir_ack        (ir_ack),
    .pc_load       (pc_load),
    .pc_load_value (pc_load_value)
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    .fetch_fault   (fetch_fault)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        ld;
    logic [31:0] val;
    int unsigned dly;
    logic [31:0] data;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t vecs[6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual %h required %h", name, act, exp);
    end
  endtask

  // Called in the REQ cycle; memory answers dly cycles after the strobe.
  task automatic serve(input logic [31:0] data, input int unsigned dly);
    tick();
    for (int unsigned k = 1; k < dly; k++) begin
      chk("wait_rd_en", {31'd0, imem_rd_en}, 32'd0);
      chk("wait_ir_valid", {31'd0, ir_valid}, 32'd0);
      tick();
    end
    imem_rd_valid = 1'b1;
    imem_rd_data  = data;
    tick();
    imem_rd_valid = 1'b0;
    imem_rd_data  = 32'hDEAD_BEEF;
    chk("capture_ir", ir, data);
    chk("capture_ir_valid", {31'd0, ir_valid}, 32'd1);
    chk("capture_rd_en", {31'd0, imem_rd_en}, 32'd0);
  endtask

  task automatic ack(input logic ld, input logic [31:0] val);
    ir_ack        = 1'b1;
    pc_load       = ld;
    pc_load_value = val;
    tick();
    ir_ack        = 1'b0;
    pc_load       = 1'b0;
    pc_load_value = 32'h0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset = 1'b1;
    imem_rd_data  = 32'hDEAD_BEEF;
    imem_rd_valid = 1'b0;
    ir_ack        = 1'b0;
    pc_load       = 1'b0;
    pc_load_value = 32'h0;

    vecs[0] = '{ld: 1'b0, val: 32'h0,         dly: 5, data: 32'h00A0_0113, exp_pc: 32'h0000_0004};
    vecs[1] = '{ld: 1'b1, val: 32'h0000_0100, dly: 1, data: 32'h0010_0193, exp_pc: 32'h0000_0100};
    vecs[2] = '{ld: 1'b1, val: 32'hFFFF_FFFC, dly: 1, data: 32'h0020_0213, exp_pc: 32'hFFFF_FFFC};
    vecs[3] = '{ld: 1'b0, val: 32'h0,         dly: 2, data: 32'h0030_0293, exp_pc: 32'h0000_0000};
`ifdef FETCH_MISALIGN_TRAP_EN
    vecs[4] = '{ld: 1'b1, val: 32'h0000_0100, dly: 1, data: 32'h0040_0313, exp_pc: 32'h0000_0100};
`else
    vecs[4] = '{ld: 1'b1, val: 32'h0000_0102, dly: 1, data: 32'h0040_0313, exp_pc: 32'h0000_0100};
`endif
    vecs[5] = '{ld: 1'b0, val: 32'h0,         dly: 1, data: 32'h0050_0393, exp_pc: 32'h0000_0104};

    // Reset state and first request
    do_reset();
    chk("rst_pc", pc, 32'h0);
    chk("rst_ir", ir, 32'h0000_0013);
    chk("rst_ir_valid", {31'd0, ir_valid}, 32'd0);
    chk("rst_rd_en", {31'd0, imem_rd_en}, 32'd1);
    chk("rst_addr", imem_addr, 32'h0);
`ifdef FETCH_MISALIGN_TRAP_EN
    chk("rst_fault", {31'd0, fetch_fault}, 32'd0);
`endif

    // First fetch, then hold without acknowledge (stray pc_load included)
    serve(32'h0050_0093, 1);
    for (int unsigned c = 0; c < 10; c++) begin
      if (c >= 5) begin
        pc_load       = 1'b1;
        pc_load_value = 32'h0000_0200;
      end
      tick();
      chk("hold_ir", ir, 32'h0050_0093);
      chk("hold_pc", pc, 32'h0);
      chk("hold_rd_en", {31'd0, imem_rd_en}, 32'd0);
      chk("hold_ir_valid", {31'd0, ir_valid}, 32'd1);
    end
    pc_load       = 1'b0;
    pc_load_value = 32'h0;

    // Table: acknowledge, check the next request, serve it
    for (int unsigned i = 0; i < 6; i++) begin
      ack(vecs[i].ld, vecs[i].val);
      chk("ack_ir_valid", {31'd0, ir_valid}, 32'd0);
      chk("ack_rd_en", {31'd0, imem_rd_en}, 32'd1);
      chk("ack_addr", imem_addr, vecs[i].exp_pc);
      chk("ack_pc", pc, vecs[i].exp_pc);
      chk("ack_pc_plus4", pc_plus4, vecs[i].exp_pc + 32'd4);
      serve(vecs[i].data, vecs[i].dly);
      chk("vec_pc", pc, vecs[i].exp_pc);
    end

`ifdef FETCH_MISALIGN_TRAP_EN
    // Misaligned redirect traps; sticky until reset
    ack(1'b1, 32'h0000_0102);
    chk("flt_fault", {31'd0, fetch_fault}, 32'd1);
    chk("flt_ir_valid", {31'd0, ir_valid}, 32'd0);
    chk("flt_pc", pc, 32'h0000_0104);
    for (int unsigned c = 0; c < 6; c++) begin
      ir_ack        = 1'b1;
      imem_rd_valid = 1'b1;
      tick();
      chk("flt_rd_en", {31'd0, imem_rd_en}, 32'd0);
      chk("flt_sticky", {31'd0, fetch_fault}, 32'd1);
    end
    ir_ack        = 1'b0;
    imem_rd_valid = 1'b0;
    do_reset();
    chk("flt_rst_fault", {31'd0, fetch_fault}, 32'd0);
    chk("flt_rst_rd_en", {31'd0, imem_rd_en}, 32'd1);
    chk("flt_rst_addr", imem_addr, 32'h0);
    serve(32'h0060_0413, 1);
`endif

    // Reset while a read is outstanding abandons it
    ack(1'b0, 32'h0);
    tick();
    chk("mid_wait_rd_en", {31'd0, imem_rd_en}, 32'd0);
    do_reset();
    chk("mid_rst_pc", pc, 32'h0);
    chk("mid_rst_ir", ir, 32'h0000_0013);
    chk("mid_rst_ir_valid", {31'd0, ir_valid}, 32'd0);
    chk("mid_rst_rd_en", {31'd0, imem_rd_en}, 32'd1);
    serve(32'h0070_0493, 1);
    chk("mid_rst_pc_after", pc, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
